// File: rtl/async_fifo_package.sv
// Shared defaults and state type for the single-clock FIFO storage array.
package async_fifo_package;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH      = 16;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;

  typedef enum logic {INIT, RUN} ram_state_t;
endpackage

// File: rtl/ram_read_pipe.sv
// Optional second output register for the read path. With RD_LATENCY=1 it is a pass-through.
module ram_read_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_oob,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_oob
);

  if (RD_LATENCY == 2) begin : g_stage
    logic                  valid_q;
    logic                  oob_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Data only moves when a read completes so the output holds between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        oob_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= in_valid;
        oob_q   <= in_valid & in_oob;
        if (in_valid) data_q <= in_data;
      end
    end

    assign out_valid = valid_q;
    assign out_oob   = oob_q;
    assign out_data  = data_q;
  end else begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rst};
    assign out_valid = in_valid;
    assign out_oob   = in_oob;
    assign out_data  = in_data;
  end

endmodule

// File: rtl/sync_dualport_ram.sv
// Single-clock 1W/1R RAM with byte enables, post-reset self-clear sweep and out-of-range flags.
//   state | meaning
//   INIT  | self-clear sweep writing '0 to mem[init_ptr]
//   RUN   | normal read/write operation
module sync_dualport_ram
  import async_fifo_package::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_be,
  input  logic                    r_en,
  input  logic [ADDR_WIDTH-1:0]   r_addr,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    r_valid,
  output logic                    ready,
  output logic                    w_oob,
  output logic                    r_oob
);

  localparam int                  BE_W      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (DATA_WIDTH % 8 != 0) begin : g_err_dw
    $error("sync_dualport_ram: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_err_depth
    $error("sync_dualport_ram: DEPTH exceeds 2**ADDR_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_err_lat
    $error("sync_dualport_ram: RD_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ram_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_ptr_q, init_ptr_d;

  logic                  wr_in_range, rd_in_range, wr_go, rd_go;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_valid, s1_oob;
  logic [DATA_WIDTH-1:0] s1_data;

  // Gating with rst keeps a request presented alongside reset from being accepted.
  assign ready       = (state_q == RUN) & ~rst;
  assign wr_in_range = {1'b0, w_addr} < DEPTH_L;
  assign rd_in_range = {1'b0, r_addr} < DEPTH_L;
  assign wr_go       = ready & w_en & wr_in_range;
  assign rd_go       = ready & r_en;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_ADDR) begin
          state_d    = RUN;
          init_ptr_d = '0;
        end
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == INIT) begin
      mem[init_ptr_q] <= '0;
    end else if (wr_go) begin
      for (int i = 0; i < BE_W; i++) begin
        if (w_be[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // New-data mode forwards the enabled write lanes over the stored word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[r_addr];
      if (RDW_MODE == 1 && wr_go && w_addr == r_addr) begin
        for (int i = 0; i < BE_W; i++) begin
          if (w_be[i]) rd_word[8*i +: 8] = w_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_data  <= '0;
      w_oob    <= 1'b0;
    end else begin
      s1_valid <= rd_go;
      s1_oob   <= rd_go & ~rd_in_range;
      if (rd_go) s1_data <= rd_word;
      w_oob    <= ready & w_en & ~wr_in_range;
    end
  end

  ram_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_data   (s1_data),
    .in_oob    (s1_oob),
    .out_valid (r_valid),
    .out_data  (r_data),
    .out_oob   (r_oob)
  );

endmodule
